// File: rtl/dbus_pkg.sv
// Shared definitions for the data-bus copy master: FSM state encoding,
// bus access-size codes and a small address helper.
package dbus_pkg;

   // Copy engine states, in the order a normal word transfer visits them
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_CMD  = 3'd1,
      RD_WAIT = 3'd2,
      WR_CMD  = 3'd3,
      DONE    = 3'd4
   } copy_state_t;

   // Access size codes carried on dBus_cmd_payload_size
   localparam logic [1:0] DBUS_SIZE_BYTE = 2'd0;
   localparam logic [1:0] DBUS_SIZE_HALF = 2'd1;
   localparam logic [1:0] DBUS_SIZE_WORD = 2'd2;

   // Byte distance between consecutive words
   localparam logic [31:0] WORD_STEP = 32'd4;

   // Drop the byte-offset bits so every access is word aligned
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/dbus_copy_master_if.sv
// Data-bus command/response channel. The copy master drives commands and
// consumes read responses; the responder owns ready and the response fields.
interface dbus_copy_master_if;

   logic        dBus_cmd_valid;
   logic        dBus_cmd_ready;
   logic        dBus_cmd_payload_wr;
   logic [31:0] dBus_cmd_payload_address;
   logic [31:0] dBus_cmd_payload_data;
   logic [1:0]  dBus_cmd_payload_size;
   logic        dBus_rsp_ready;
   logic        dBus_rsp_error;
   logic [31:0] dBus_rsp_data;

   modport master (
      output dBus_cmd_valid,
      input  dBus_cmd_ready,
      output dBus_cmd_payload_wr,
      output dBus_cmd_payload_address,
      output dBus_cmd_payload_data,
      output dBus_cmd_payload_size,
      input  dBus_rsp_ready,
      input  dBus_rsp_error,
      input  dBus_rsp_data
   );

   modport slave (
      input  dBus_cmd_valid,
      output dBus_cmd_ready,
      input  dBus_cmd_payload_wr,
      input  dBus_cmd_payload_address,
      input  dBus_cmd_payload_data,
      input  dBus_cmd_payload_size,
      output dBus_rsp_ready,
      output dBus_rsp_error,
      output dBus_rsp_data
   );

endinterface

// File: rtl/dbus_copy_master.sv
// Word-by-word memory copy engine on the data bus. Each word is read from
// the source, held, then written to the destination; only one read is ever
// outstanding. Command outputs are decoded from the state so they vanish the
// moment reset is applied and stay stable while a command waits for ready.
module dbus_copy_master
   import dbus_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [31:0]        src_addr,
   input  logic [31:0]        dst_addr,
   input  logic [CNT_W-1:0]   word_count,
   output logic               busy,
   output logic               done,
   output logic               error,
   dbus_copy_master_if.master dbus
);

   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_ZERO + 1'b1;

   copy_state_t      state;
   copy_state_t      state_next;
   logic [31:0]      src_q;
   logic [31:0]      dst_q;
   logic [31:0]      word_q;
   logic [CNT_W-1:0] remaining_q;

   logic             cmd_valid;
   logic             cmd_wr;
   logic [31:0]      cmd_address;
   logic [31:0]      cmd_data;
   logic [1:0]       cmd_size;

   // State register; reset parks the engine in IDLE immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and bus/status decode; address and data only leave zero in the command states
   always_comb begin
      state_next  = state;
      busy        = 1'b0;
      done        = 1'b0;
      cmd_valid   = 1'b0;
      cmd_wr      = 1'b0;
      cmd_address = 32'd0;
      cmd_data    = 32'd0;
      cmd_size    = DBUS_SIZE_WORD;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = (word_count == CNT_ZERO) ? DONE : RD_CMD;
            end
         end
         RD_CMD: begin
            busy        = 1'b1;
            cmd_valid   = 1'b1;
            cmd_address = src_q;
            if (dbus.dBus_cmd_ready) begin
               state_next = RD_WAIT;
            end
         end
         RD_WAIT: begin
            busy = 1'b1;
            if (dbus.dBus_rsp_ready) begin
               state_next = dbus.dBus_rsp_error ? DONE : WR_CMD;
            end
         end
         WR_CMD: begin
            busy        = 1'b1;
            cmd_valid   = 1'b1;
            cmd_wr      = 1'b1;
            cmd_address = dst_q;
            cmd_data    = word_q;
            if (dbus.dBus_cmd_ready) begin
               state_next = (remaining_q == CNT_ONE) ? DONE : RD_CMD;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Copy datapath: capture the job on start, hold the read word, advance pointers after each write
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         src_q       <= 32'd0;
         dst_q       <= 32'd0;
         word_q      <= 32'd0;
         remaining_q <= CNT_ZERO;
         error       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  src_q       <= word_align(src_addr);
                  dst_q       <= word_align(dst_addr);
                  remaining_q <= word_count;
                  error       <= 1'b0;
               end
            end
            RD_WAIT: begin
               if (dbus.dBus_rsp_ready) begin
                  if (dbus.dBus_rsp_error) begin
                     error <= 1'b1;
                  end else begin
                     word_q <= dbus.dBus_rsp_data;
                  end
               end
            end
            WR_CMD: begin
               if (dbus.dBus_cmd_ready) begin
                  remaining_q <= remaining_q - CNT_ONE;
                  src_q       <= src_q + WORD_STEP;
                  dst_q       <= dst_q + WORD_STEP;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign dbus.dBus_cmd_valid           = cmd_valid;
   assign dbus.dBus_cmd_payload_wr      = cmd_wr;
   assign dbus.dBus_cmd_payload_address = cmd_address;
   assign dbus.dBus_cmd_payload_data    = cmd_data;
   assign dbus.dBus_cmd_payload_size    = cmd_size;

endmodule

// File: tb/tb_dbus_copy_master.sv
// Bench for the data-bus copy master. A bus responder answers commands with
// optional stalls and error injection; every command the master issues is
// matched against a queue of expected accesses built when each copy starts.
module tb_dbus_copy_master;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
   } cmd_t;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] src_addr;
   logic [31:0] dst_addr;
   logic [15:0] word_count;
   logic        busy;
   logic        done;
   logic        error;

   dbus_copy_master_if bus ();

   dbus_copy_master #(.CNT_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .word_count (word_count),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .dbus       (bus)
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   cmd_t        exp_q[$];
   int          stall_cycles = 0;
   int          stall_cnt = 0;
   int          err_idx = -1;
   int          rsp_idx = 0;
   bit          rsp_pending = 0;
   bit          stray_rsp = 0;
   logic [31:0] pending_addr = 32'd0;

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used for latency measurements
   always @(posedge clk) cyc <= cyc + 1;

   // Hard stop in case something wedges despite the bounded waits
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Deterministic read data so every address yields a distinct word
   function automatic logic [31:0] rd_data(input logic [31:0] a);
      return (a ^ 32'h5A5A_1234) + 32'h0101_0000;
   endfunction

   task automatic check_output(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   // Bus responder: stalls commands, answers reads one cycle after acceptance
   initial begin : responder
      cmd_t        e;
      logic [34:0] snap_ctl;
      logic [31:0] snap_data;
      bus.dBus_cmd_ready = 1'b0;
      bus.dBus_rsp_ready = 1'b0;
      bus.dBus_rsp_error = 1'b0;
      bus.dBus_rsp_data  = 32'd0;
      snap_ctl  = '0;
      snap_data = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            rsp_pending        = 0;
            stall_cnt          = 0;
            bus.dBus_cmd_ready = 1'b0;
            bus.dBus_rsp_ready = 1'b0;
            bus.dBus_rsp_error = 1'b0;
         end else begin
            if (rsp_pending || stray_rsp) begin
               bus.dBus_rsp_ready = 1'b1;
               bus.dBus_rsp_error = stray_rsp || (rsp_idx == err_idx);
               bus.dBus_rsp_data  = rd_data(pending_addr);
               if (!stray_rsp) rsp_idx++;
            end else begin
               bus.dBus_rsp_ready = 1'b0;
               bus.dBus_rsp_error = 1'b0;
            end
            rsp_pending = 0;
            stray_rsp   = 0;
            if (bus.dBus_cmd_valid) begin
               if (stall_cnt == 0) begin
                  snap_ctl  = {bus.dBus_cmd_payload_wr, bus.dBus_cmd_payload_size,
                               bus.dBus_cmd_payload_address};
                  snap_data = bus.dBus_cmd_payload_data;
               end else begin
                  check_output("payload_stable_ctl",
                               {bus.dBus_cmd_payload_wr, bus.dBus_cmd_payload_size,
                                bus.dBus_cmd_payload_address}, snap_ctl);
                  check_output("payload_stable_data", bus.dBus_cmd_payload_data, snap_data);
               end
               if (stall_cnt < stall_cycles) begin
                  bus.dBus_cmd_ready = 1'b0;
                  stall_cnt++;
               end else begin
                  bus.dBus_cmd_ready = 1'b1;
                  stall_cnt = 0;
                  check_output("cmd_expected", exp_q.size() > 0, 1);
                  if (exp_q.size() > 0) begin
                     e = exp_q.pop_front();
                     check_output("cmd_wr", bus.dBus_cmd_payload_wr, e.wr);
                     check_output("cmd_addr", bus.dBus_cmd_payload_address, e.addr);
                     check_output("cmd_size", bus.dBus_cmd_payload_size, 2);
                     if (e.wr) check_output("cmd_data", bus.dBus_cmd_payload_data, e.data);
                  end
                  if (!bus.dBus_cmd_payload_wr) begin
                     rsp_pending  = 1;
                     pending_addr = bus.dBus_cmd_payload_address;
                  end
               end
            end else begin
               bus.dBus_cmd_ready = (stall_cycles == 0);
            end
         end
      end
   end

   // Queue the expected reads/writes of a copy, stopping after the failing read
   task automatic apply_stimulus(input logic [31:0] s, input logic [31:0] d, input int n,
                                 input int stall, input int err);
      logic [31:0] a_src;
      logic [31:0] a_dst;
      stall_cycles = stall;
      err_idx      = err;
      rsp_idx      = 0;
      a_src = s & 32'hFFFF_FFFC;
      a_dst = d & 32'hFFFF_FFFC;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back('{wr: 1'b0, addr: a_src, data: 32'd0});
         if (i == err) break;
         exp_q.push_back('{wr: 1'b1, addr: a_dst, data: rd_data(a_src)});
         a_src = a_src + 32'd4;
         a_dst = a_dst + 32'd4;
      end
      @(negedge clk);
      src_addr   = s;
      dst_addr   = d;
      word_count = 16'(n);
      start      = 1'b1;
   endtask

   // Run one copy to completion and check latency, status and scoreboard drain
   task automatic run_copy(input string name, input logic [31:0] s, input logic [31:0] d,
                           input int n, input int stall, input int err, input int poke,
                           input int exp_lat, input logic exp_err);
      int c0;
      int lat;
      bit got;
      bit busy_seen;
      got = 0;
      busy_seen = 0;
      lat = -1;
      apply_stimulus(s, d, n, stall, err);
      c0 = cyc;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (k == 0) begin
            start = 1'b0;
            check_output({name, "_error_cleared"}, error, 0);
         end
         if (k == poke) begin
            start      = 1'b1;
            src_addr   = 32'h0000_ABC0;
            dst_addr   = 32'h0000_DEF0;
            word_count = 16'd7;
         end
         if (k == poke + 1) start = 1'b0;
         if (busy) busy_seen = 1;
         if (done) begin
            lat = cyc - c0;
            got = 1;
            break;
         end
      end
      start = 1'b0;
      check_output({name, "_done_seen"}, got, 1);
      if (exp_lat >= 0) check_output({name, "_latency"}, lat, exp_lat);
      if (n == 0) check_output({name, "_busy_never"}, busy_seen, 0);
      check_output({name, "_error"}, error, exp_err);
      check_output({name, "_busy_at_done"}, busy, 0);
      @(negedge clk);
      check_output({name, "_done_one_cycle"}, done, 0);
      check_output({name, "_error_held"}, error, exp_err);
      check_output({name, "_sb_drained"}, exp_q.size(), 0);
   endtask

   // Main sequence
   initial begin : main
      bit found;
      reset      = 1'b1;
      start      = 1'b0;
      src_addr   = 32'd0;
      dst_addr   = 32'd0;
      word_count = 16'd0;
      repeat (2) @(negedge clk);
      check_output("rst_busy", busy, 0);
      check_output("rst_done", done, 0);
      check_output("rst_error", error, 0);
      check_output("rst_valid", bus.dBus_cmd_valid, 0);
      check_output("rst_wr", bus.dBus_cmd_payload_wr, 0);
      check_output("rst_addr", bus.dBus_cmd_payload_address, 0);
      check_output("rst_data", bus.dBus_cmd_payload_data, 0);
      check_output("rst_size", bus.dBus_cmd_payload_size, 2);
      reset = 1'b0;
      @(negedge clk);
      check_output("idle_busy", busy, 0);

      run_copy("basic3", 32'h0000_0100, 32'h0000_0200, 3, 0, -1, -1, 10, 1'b0);
      run_copy("empty", 32'h0000_0700, 32'h0000_0800, 0, 0, -1, -1, 1, 1'b0);
      run_copy("stall2", 32'h0000_1000, 32'h0000_2000, 2, 4, -1, 2, -1, 1'b0);
      run_copy("rderr", 32'h0000_3000, 32'h0000_4000, 4, 0, 1, -1, 6, 1'b1);
      repeat (4) @(negedge clk);
      check_output("rderr_quiet_valid", bus.dBus_cmd_valid, 0);
      check_output("rderr_sticky", error, 1);
      run_copy("clrerr", 32'h0000_5000, 32'h0000_6000, 1, 0, -1, -1, 4, 1'b0);
      run_copy("wrap", 32'hFFFF_FFFC, 32'h0000_0300, 2, 0, -1, -1, 7, 1'b0);
      run_copy("unalign", 32'h0000_0103, 32'h0000_0402, 1, 0, -1, -1, 4, 1'b0);

      // Reset while a write is being held off by the responder
      apply_stimulus(32'h0000_0500, 32'h0000_0600, 2, 4, -1);
      found = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (k == 0) start = 1'b0;
         if (bus.dBus_cmd_valid && bus.dBus_cmd_payload_wr) begin
            found = 1;
            break;
         end
      end
      start = 1'b0;
      check_output("rstmid_reached_wr", found, 1);
      #2;
      reset = 1'b1;
      #1;
      check_output("rstmid_valid", bus.dBus_cmd_valid, 0);
      check_output("rstmid_busy", busy, 0);
      check_output("rstmid_addr", bus.dBus_cmd_payload_address, 0);
      @(negedge clk);
      exp_q.delete();
      stall_cycles = 0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      stray_rsp = 1;
      repeat (3) @(negedge clk);
      check_output("stray_busy", busy, 0);
      check_output("stray_error", error, 0);
      check_output("stray_valid", bus.dBus_cmd_valid, 0);
      run_copy("afterrst", 32'h0000_0900, 32'h0000_0A00, 1, 0, -1, -1, 4, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
